pe_packet_receiver: RTL and testbench

- PE-side endpoint for the control-unit output protocol. It takes filter and ifmap packets that the control unit has packetized and the NoC has delivered.
- Filter packets are stored as rows in a local filter register file. Ifmap packets are dispatched as convolution jobs to the PE datapath.
- Each completed job is answered with an ack packet addressed back to the control unit; this ack frees one token in that unit's per-PE token buffer.
- Clocked, single-job-in-flight front end of one PE node.

---
 rtl/pe_rx_pkg.sv | 45 ++++
 rtl/pe_filter_regfile.sv | 39 +++
 rtl/pe_packet_receiver.sv | 156 +++++++++++++++
 tb/tb_pe_packet_receiver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_rx_pkg.sv
// Shared definitions for the PE packet receiver: packet field layout, FSM states and ack format.
package pe_rx_pkg;

  // Common header
  localparam int unsigned HdrDirLsb  = 0;
  localparam int unsigned HdrXHopLsb = 2;
  localparam int unsigned HdrYHopLsb = 5;
  localparam int unsigned HopW       = 3;
  localparam int unsigned HdrTsBit   = 8;
  localparam int unsigned HdrTypeBit = 9;

  // Filter packet
  localparam int unsigned NumRows    = 5;
  localparam int unsigned FilRowLsb  = 10;
  localparam int unsigned FilRowW    = 3;
  localparam int unsigned FilDataLsb = 13;

  // Ifmap packet; the ifmap window sits at the packet MSB
  localparam int unsigned IfmapW       = 25;
  localparam int unsigned IfmapSizeLsb = 13;
  localparam int unsigned SizeW        = 2;
  localparam int unsigned IfmapConvLsb = 15;

  // Ack packet: low bits carry {node, 0}, the rest is zero
  localparam int unsigned AckNodeLsb = 1;
  localparam int unsigned AckNodeW   = 4;
  localparam int unsigned AckLowW    = AckNodeLsb + AckNodeW;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StJob  = 2'd1,
    StBusy = 2'd2,
    StAck  = 2'd3
  } rx_state_e;

  typedef enum logic {
    PktIfmap  = 1'b0,
    PktFilter = 1'b1
  } pkt_type_e;

  function automatic logic [AckLowW-1:0] make_ack(logic [AckNodeW-1:0] node);
    return {node, 1'b0};
  endfunction

endpackage

// File: rtl/pe_filter_regfile.sv
// Five-row filter register file with a single write port, flat read-out and per-row valid mask.
module pe_filter_regfile
  import pe_rx_pkg::*;
#(
  parameter int unsigned FILTER_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [FilRowW-1:0]                 wr_row,
  input  logic [5*FILTER_WIDTH-1:0]          wr_data,
  output logic [NumRows*5*FILTER_WIDTH-1:0]  fil_flat,
  output logic [NumRows-1:0]                 rows_valid
);

  localparam int unsigned RowW = 5 * FILTER_WIDTH;

  logic [RowW-1:0]    rows_q [NumRows];
  logic [NumRows-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NumRows; r++) begin
        rows_q[r] <= '0;
      end
      valid_q <= '0;
    end else if (wr_en && (wr_row < FilRowW'(NumRows))) begin
      rows_q[wr_row]  <= wr_data;
      valid_q[wr_row] <= 1'b1;
    end
  end

  for (genvar r = 0; r < NumRows; r++) begin : g_flat
    assign fil_flat[r*RowW +: RowW] = rows_q[r];
  end

  assign rows_valid = valid_q;

endmodule

// File: rtl/pe_packet_receiver.sv
// PE-side packet endpoint: stores filter rows, dispatches one ifmap job at a time, acks completion.
// Optional misroute filtering and drop counting are enabled by defining PE_RX_HOP_CHECK_EN.
module pe_packet_receiver
  import pe_rx_pkg::*;
#(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned PE_NODE      = 0,
  parameter int unsigned IN_W         = 5 * FILTER_WIDTH + 13,
  parameter int unsigned ACK_W        = 5 * FILTER_WIDTH + 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IN_W-1:0]              in_pkt,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [25*FILTER_WIDTH-1:0]   fil_flat,
  output logic [4:0]                   fil_rows_valid,
  output logic                         job_valid,
  input  logic                         job_ready,
  output logic [IfmapW-1:0]            job_ifmap,
  output logic [IN_W-41:0]             job_conv_loc,
  output logic [SizeW-1:0]             job_size,
  output logic                         job_timestep,
  input  logic                         pe_done,
  output logic [ACK_W-1:0]             ack_pkt,
  output logic                         ack_valid,
  input  logic                         ack_ready,
  output logic [7:0]                   err_cnt
);

  localparam int unsigned ConvW = IN_W - 40;

  rx_state_e state_q, state_d;

  logic [IfmapW-1:0]  ifmap_q;
  logic [ConvW-1:0]   conv_q;
  logic [SizeW-1:0]   size_q;
  logic               ts_q;
  logic [ACK_W-1:0]   ack_q;

  logic               fil_we;
  logic               load_job;
  logic               load_ack;
  logic               drop;
  logic               hop_bad;

  pkt_type_e          pkt_type;
  logic [FilRowW-1:0] pkt_row;
  logic [SizeW-1:0]   pkt_size;

  assign pkt_type = pkt_type_e'(in_pkt[HdrTypeBit]);
  assign pkt_row  = in_pkt[FilRowLsb +: FilRowW];
  assign pkt_size = in_pkt[IfmapSizeLsb +: SizeW];

`ifdef PE_RX_HOP_CHECK_EN
  assign hop_bad = |{in_pkt[HdrYHopLsb +: HopW], in_pkt[HdrXHopLsb +: HopW]};
`else
  assign hop_bad = 1'b0;
`endif

  // Direction bits are never used; hop bits and drop only matter with the hop check built in.
  logic unused_hdr;
  assign unused_hdr = ^{in_pkt[HdrDirLsb +: 2], in_pkt[HdrXHopLsb +: 2*HopW], drop};

  always_comb begin
    state_d  = state_q;
    fil_we   = 1'b0;
    load_job = 1'b0;
    load_ack = 1'b0;
    drop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (hop_bad) begin
            drop = 1'b1;
          end else if (pkt_type == PktFilter) begin
            if (pkt_row < FilRowW'(NumRows)) fil_we = 1'b1;
            else                             drop   = 1'b1;
          end else if (pkt_size != '0) begin
            load_job = 1'b1;
            state_d  = StJob;
          end else begin
            drop = 1'b1;
          end
        end
      end
      StJob:  if (job_ready) state_d = StBusy;
      StBusy: begin
        if (pe_done) begin
          load_ack = 1'b1;
          state_d  = StAck;
        end
      end
      StAck:  if (ack_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ifmap_q <= '0;
      conv_q  <= '0;
      size_q  <= '0;
      ts_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_job) begin
        ifmap_q <= in_pkt[IN_W-1 -: IfmapW];
        conv_q  <= in_pkt[IfmapConvLsb +: ConvW];
        size_q  <= pkt_size;
        ts_q    <= in_pkt[HdrTsBit];
      end
      if (load_ack) begin
        ack_q <= {{(ACK_W-AckLowW){1'b0}}, make_ack(AckNodeW'(PE_NODE))};
      end
    end
  end

  pe_filter_regfile #(
    .FILTER_WIDTH(FILTER_WIDTH)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (fil_we),
    .wr_row    (pkt_row),
    .wr_data   (in_pkt[FilDataLsb +: 5*FILTER_WIDTH]),
    .fil_flat  (fil_flat),
    .rows_valid(fil_rows_valid)
  );

`ifdef PE_RX_HOP_CHECK_EN
  logic [7:0] err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (drop && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end
  assign err_cnt = err_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign in_ready     = (state_q == StIdle);
  assign job_valid    = (state_q == StJob);
  assign ack_valid    = (state_q == StAck);
  assign job_ifmap    = ifmap_q;
  assign job_conv_loc = conv_q;
  assign job_size     = size_q;
  assign job_timestep = ts_q;
  assign ack_pkt      = ack_q;

endmodule

// File: tb/tb_pe_packet_receiver.sv
// Directed self-checking bench for pe_packet_receiver (PE_NODE = 5).
module tb_pe_packet_receiver;

  localparam int unsigned FW    = 8;
  localparam int unsigned IN_W  = 5 * FW + 13;
  localparam int unsigned ACK_W = 5 * FW + 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [IN_W-1:0]     in_pkt;
  logic                in_valid;
  logic                in_ready;
  logic [25*FW-1:0]    fil_flat;
  logic [4:0]          fil_rows_valid;
  logic                job_valid;
  logic                job_ready;
  logic [24:0]         job_ifmap;
  logic [IN_W-41:0]    job_conv_loc;
  logic [1:0]          job_size;
  logic                job_timestep;
  logic                pe_done;
  logic [ACK_W-1:0]    ack_pkt;
  logic                ack_valid;
  logic                ack_ready;
  logic [7:0]          err_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pe_packet_receiver #(
    .FILTER_WIDTH(FW),
    .PE_NODE     (5),
    .IN_W        (IN_W),
    .ACK_W       (ACK_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_pkt        (in_pkt),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fil_flat      (fil_flat),
    .fil_rows_valid(fil_rows_valid),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_ifmap     (job_ifmap),
    .job_conv_loc  (job_conv_loc),
    .job_size      (job_size),
    .job_timestep  (job_timestep),
    .pe_done       (pe_done),
    .ack_pkt       (ack_pkt),
    .ack_valid     (ack_valid),
    .ack_ready     (ack_ready),
    .err_cnt       (err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] fil_pkt(input logic [2:0] row, input logic [39:0] data,
                                              input logic [2:0] xhop);
    return {data, row, 1'b1, 1'b0, 3'b000, xhop, 2'b00};
  endfunction

  function automatic logic [IN_W-1:0] ifm_pkt(input logic [24:0] ifm, input logic [12:0] conv,
                                              input logic [1:0] size, input logic ts);
    return {ifm, conv, size, 3'b000, 1'b0, ts, 8'h00};
  endfunction

  logic [7:0] exp_err;

  initial begin
    rst_n     = 1'b0;
    in_pkt    = '0;
    in_valid  = 1'b0;
    job_ready = 1'b0;
    pe_done   = 1'b0;
    ack_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_fil_flat_any", 64'(|fil_flat), 64'd0);
    check("rst_rows_valid", 64'(fil_rows_valid), 64'd0);
    check("rst_job_valid", 64'(job_valid), 64'd0);
    check("rst_job_ifmap", 64'(job_ifmap), 64'd0);
    check("rst_ack_valid", 64'(ack_valid), 64'd0);
    check("rst_ack_pkt", 64'(ack_pkt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);

    // Filter row 1 write
    in_pkt   = fil_pkt(3'd1, 40'h0504030201, 3'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fil_row1_data", 64'(fil_flat[79:40]), 64'h0504030201);
    check("fil_row0_clear", 64'(fil_flat[39:0]), 64'd0);
    check("fil_rows_valid1", 64'(fil_rows_valid), 64'b00010);

    // Row 6 dropped, then size-0 ifmap dropped
    in_pkt   = fil_pkt(3'd6, 40'hFFFFFFFFFF, 3'd0);
    in_valid = 1'b1;
    tick();
    check("row6_rows_valid", 64'(fil_rows_valid), 64'b00010);
    in_pkt = ifm_pkt(25'h1234567, 13'd3, 2'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    check("size0_no_job", 64'(job_valid), 64'd0);
    check("size0_in_ready", 64'(in_ready), 64'd1);
`ifdef PE_RX_HOP_CHECK_EN
    exp_err = 8'd2;
`else
    exp_err = 8'd0;
`endif
    check("drops_err_cnt", 64'(err_cnt), 64'(exp_err));

    // pe_done in IDLE is ignored
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    check("idle_pe_done_ack", 64'(ack_valid), 64'd0);

    // Ifmap job
    in_pkt   = ifm_pkt(25'h1FFFFFF, 13'd7, 2'd1, 1'b1);
    in_valid = 1'b1;
    tick();
    check("job_valid", 64'(job_valid), 64'd1);
    check("job_ifmap", 64'(job_ifmap), 64'h1FFFFFF);
    check("job_conv_loc", 64'(job_conv_loc), 64'd7);
    check("job_size", 64'(job_size), 64'd1);
    check("job_timestep", 64'(job_timestep), 64'd1);
    check("job_in_ready", 64'(in_ready), 64'd0);

    // Second ifmap offered while stalled must not disturb the held job
    in_pkt = ifm_pkt(25'h0000AAA, 13'd99, 2'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_job_valid", 64'(job_valid), 64'd1);
      check("stall_job_ifmap", 64'(job_ifmap), 64'h1FFFFFF);
      check("stall_job_conv", 64'(job_conv_loc), 64'd7);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    check("busy_job_valid", 64'(job_valid), 64'd0);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    check("busy_ack_valid", 64'(ack_valid), 64'd0);

    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    check("ack_valid", 64'(ack_valid), 64'd1);
    check("ack_pkt", 64'(ack_pkt), 64'h0A);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ack_hold_valid", 64'(ack_valid), 64'd1);
      check("ack_hold_pkt", 64'(ack_pkt), 64'h0A);
      check("ack_hold_in_ready", 64'(in_ready), 64'd0);
    end
    ack_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    ack_ready = 1'b0;
    check("post_ack_valid", 64'(ack_valid), 64'd0);
    check("post_ack_in_ready", 64'(in_ready), 64'd1);
    check("post_ack_no_job", 64'(job_valid), 64'd0);

    // Reset while BUSY discards the job
    in_pkt   = ifm_pkt(25'h0F0F0F0, 13'd5, 2'd3, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    check("pre_rst_busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    tick();
    check("rst_busy_ack_valid", 64'(ack_valid), 64'd0);
    check("rst_busy_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy_rows_valid", 64'(fil_rows_valid), 64'd0);
    check("rst_busy_job_valid", 64'(job_valid), 64'd0);
    check("rst_busy_err_cnt", 64'(err_cnt), 64'd0);

    // Misrouted filter packet
    in_pkt   = fil_pkt(3'd2, 40'h1122334455, 3'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef PE_RX_HOP_CHECK_EN
    check("hop_rows_valid", 64'(fil_rows_valid), 64'd0);
    check("hop_err_cnt", 64'(err_cnt), 64'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    check("err_cnt_saturate", 64'(err_cnt), 64'd255);
`else
    check("hop_ignored_rows_valid", 64'(fil_rows_valid), 64'b00100);
    check("hop_ignored_row2", 64'(fil_flat[119:80]), 64'h1122334455);
    check("hop_err_cnt", 64'(err_cnt), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
